// File: rtl/writeback_unit.sv
// writeback_unit: selects the MEM/WB result and arbitrates the register-file write port against buffered mul/div results
module writeback_unit #(
    parameter int XLEN       = 32,
    parameter int PEND_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RegWriteW,
    input  logic [1:0]                    ResultSrcW,
    input  logic [XLEN-1:0]               ALUResultW,
    input  logic [XLEN-1:0]               ReadDataW,
    input  logic [4:0]                    RdW,
    input  logic [XLEN-1:0]               PCPlus4W,
    input  logic                          md_valid,
    input  logic [4:0]                    md_rd,
    input  logic [XLEN-1:0]               md_result,
    output logic                          md_ready,
    output logic [XLEN-1:0]               ResultW,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_wd,
    output logic [$clog2(PEND_DEPTH):0]   pend_count
);
    localparam int AW = $clog2(PEND_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(PEND_DEPTH);

    logic [4:0]            q_rd   [PEND_DEPTH];
    logic [XLEN-1:0]       q_data [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] q_ok;
    logic [AW-1:0]         head, tail;
    logic                  live, nonempty, pop, drop, push;

    always_comb ResultW = ResultSrcW == 2'b01 ? ReadDataW :
                          ResultSrcW == 2'b10 ? PCPlus4W  : ALUResultW;

    assign live     = RegWriteW && RdW != 5'd0;
    assign md_ready = pend_count < FULL;
    assign nonempty = pend_count != '0;
    assign drop     = nonempty && !q_ok[head];
    assign pop      = nonempty && q_ok[head] && !live;
    assign push     = md_valid && md_ready && md_rd != 5'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            head       <= '0;
            tail       <= '0;
            pend_count <= '0;
            q_ok       <= '0;
        end else begin
            rf_we <= live || pop;
            if (live) begin
                rf_rd <= RdW;
                rf_wd <= ResultW;
            end else if (pop) begin
                rf_rd <= q_rd[head];
                rf_wd <= q_data[head];
            end
            // invalidate older entries first so a same-cycle push stays valid
            for (int i = 0; i < PEND_DEPTH; i++)
                if (live && q_rd[i] == RdW)
                    q_ok[i] <= 1'b0;
            if (push) begin
                q_ok[tail] <= 1'b1;
                tail       <= tail + AW'(1);
            end
            if (pop || drop)
                head <= head + AW'(1);
            pend_count <= pend_count + (AW+1)'(push) - (AW+1)'(pop || drop);
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            q_rd[tail]   <= md_rd;
            q_data[tail] <= md_result;
        end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random checks of writeback_unit against a queue-based reference model
module tb_writeback_unit;
    localparam int XLEN = 32;
    localparam int D    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W, md_result;
    logic [4:0]      RdW, md_rd;
    logic            md_valid;
    logic            md_ready;
    logic [XLEN-1:0] ResultW;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [$clog2(D):0] pend_count;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(XLEN), .PEND_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_ready(md_ready),
        .ResultW(ResultW), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .pend_count(pend_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        bit          v;
    } ent_t;

    ent_t        q[$];
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycle(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [31:0] pc, input logic [4:0] rd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
        logic [31:0] res;
        bit live, ready;
        RegWriteW = rw; ResultSrcW = src; ALUResultW = alu; ReadDataW = rdat;
        PCPlus4W = pc; RdW = rd; md_valid = mv; md_rd = mrd; md_result = mres;
        #1;
        res = src == 2'd1 ? rdat : src == 2'd2 ? pc : alu;
        ready = q.size() < D;
        check("ResultW", ResultW, res);
        check("md_ready", 32'(md_ready), 32'(ready));
        live = rw && rd != 5'd0;
        e_we = live;
        if (live) begin
            e_rd = rd;
            e_wd = res;
        end
        if (q.size() > 0 && !q[0].v)
            void'(q.pop_front());
        else if (q.size() > 0 && !live) begin
            e_we = 1'b1;
            e_rd = q[0].rd;
            e_wd = q[0].d;
            void'(q.pop_front());
        end
        if (live)
            foreach (q[i]) if (q[i].rd == rd) q[i].v = 1'b0;
        if (mv && ready && mrd != 5'd0)
            q.push_back('{mrd, mres, 1'b1});
        @(posedge clk);
        #1;
        check("rf_we", 32'(rf_we), 32'(e_we));
        check("rf_rd", 32'(rf_rd), 32'(e_rd));
        check("rf_wd", rf_wd, e_wd);
        check("pend_count", 32'(pend_count), 32'(q.size()));
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        RegWriteW = 1'b0; ResultSrcW = 2'd0; ALUResultW = '0; ReadDataW = '0;
        PCPlus4W = '0; RdW = '0; md_valid = 1'b0; md_rd = '0; md_result = '0;
        e_we = 1'b0; e_rd = '0; e_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_pend", 32'(pend_count), 32'd0);
        check("rst_ready", 32'(md_ready), 32'd1);
        reset = 1'b1;

        cycle(1'b1, 2'd2, 32'h0, 32'h0, 32'h104, 5'd1, 1'b0, 5'd0, 32'd0);
        check("t1_wd", rf_wd, 32'h104);
        check("t1_rd", 32'(rf_rd), 32'd1);

        cycle(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd5, 32'hDEAD);
        idle();
        check("t2_wd", rf_wd, 32'hDEAD);

        cycle(1'b1, 2'd0, 32'h77, 32'h0, 32'h0, 5'd7, 1'b1, 5'd6, 32'h66);
        cycle(1'b1, 2'd0, 32'h78, 32'h0, 32'h0, 5'd7, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, 2'd0, 32'h79, 32'h0, 32'h0, 5'd7, 1'b0, 5'd0, 32'h0);
        check("t3_pend", 32'(pend_count), 32'd1);
        idle();
        check("t3_rd", 32'(rf_rd), 32'd6);

        cycle(1'b1, 2'd0, 32'h1, 32'h0, 32'h0, 5'd7, 1'b1, 5'd9, 32'hA);
        cycle(1'b1, 2'd0, 32'h2, 32'h0, 32'h0, 5'd7, 1'b1, 5'd10, 32'hB);
        check("t4_full", 32'(md_ready), 32'd0);
        cycle(1'b1, 2'd0, 32'h3, 32'h0, 32'h0, 5'd7, 1'b1, 5'd11, 32'hC);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd11, 32'hC);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd11, 32'hC);
        repeat (2) idle();
        check("t4_rd", 32'(rf_rd), 32'd11);

        cycle(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd8, 32'h55);
        cycle(1'b1, 2'd0, 32'h11, 32'h0, 32'h0, 5'd8, 1'b0, 5'd0, 32'h0);
        idle();
        check("t5_we", 32'(rf_we), 32'd0);
        check("t5_wd", rf_wd, 32'h11);

        cycle(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd3, 32'h33);
        cycle(1'b1, 2'd0, 32'h99, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
        check("t6_rd", 32'(rf_rd), 32'd3);

        cycle(1'b1, 2'd0, 32'h4, 32'h0, 32'h0, 5'd2, 1'b1, 5'd12, 32'hE);
        cycle(1'b1, 2'd0, 32'h5, 32'h0, 32'h0, 5'd2, 1'b1, 5'd13, 32'hF);
        #2 reset = 1'b0;
        #1;
        check("arst_we", 32'(rf_we), 32'd0);
        check("arst_pend", 32'(pend_count), 32'd0);
        check("arst_ready", 32'(md_ready), 32'd1);
        q.delete();
        e_we = 1'b0; e_rd = '0; e_wd = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle();

        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 12)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 12)), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
